// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot and periodic (auto-reload) modes and a registered expiry pulse.
// Optional sticky expiry flag is enabled with the COUNTDOWN_TIMER_STICKY_EN macro.
module countdown_timer #(
    parameter int WIDTH = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
`ifdef COUNTDOWN_TIMER_STICKY_EN
    output logic             o_expired_sticky,
`endif
    output logic             o_expired
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic             mode;

    // Busy is a direct view of the state register, so it doubles as the FSM debug output.
    assign o_busy = (state == RUN);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            o_count   <= '0;
            o_expired <= 1'b0;
            reload    <= '0;
            mode      <= 1'b0;
        end else begin
            o_expired <= 1'b0;
            if (i_clear) begin
                o_count <= '0;
                state   <= IDLE;
            end else if (i_load) begin
                reload  <= i_load_val;
                mode    <= i_mode;
                o_count <= i_load_val;
                state   <= (i_load_val != '0) ? RUN : IDLE;
            end else if (state == RUN && i_en) begin
                // In RUN the count is never 0, so reaching 1 is the only terminal case.
                if (o_count == ONE) begin
                    o_expired <= 1'b1;
                    if (mode) begin
                        o_count <= reload;
                    end else begin
                        o_count <= '0;
                        state   <= IDLE;
                    end
                end else begin
                    o_count <= o_count - ONE;
                end
            end
        end
    end

`ifdef COUNTDOWN_TIMER_STICKY_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear || i_load) begin
            o_expired_sticky <= 1'b0;
        end else if (state == RUN && i_en && o_count == ONE) begin
            o_expired_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios with literal expectations plus random stimulus,
// all checked every cycle against a tick-counting model of the timer.
module tb_countdown_timer;

    localparam int W = 12;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_en;
    logic         i_clear;
    logic         i_load;
    logic [W-1:0] i_load_val;
    logic         i_mode;
    logic [W-1:0] o_count;
    logic         o_busy;
    logic         o_expired;
`ifdef COUNTDOWN_TIMER_STICKY_EN
    logic         o_expired_sticky;
`endif

    int total = 0;
    int bad   = 0;

    countdown_timer #(.WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (i_en),
        .i_clear    (i_clear),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .i_mode     (i_mode),
        .o_count    (o_count),
        .o_busy     (o_busy),
`ifdef COUNTDOWN_TIMER_STICKY_EN
        .o_expired_sticky (o_expired_sticky),
`endif
        .o_expired  (o_expired)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ---------------- model ----------------
    // The timer is described by the loaded value and the number of enabled
    // ticks since that load; outputs are pure arithmetic on those two.
    int   m_base  = 0;
    int   m_n     = 0;
    bit   m_mode  = 0;
    bit   m_pulse = 0;
    bit   m_stick = 0;
    bit   m_valid = 0;

    typedef struct packed {
        logic         sticky;
        logic         expired;
        logic         busy;
        logic [W-1:0] count;
    } exp_t;

    logic [W+2:0] exp_q[$];

    function automatic bit m_busy();
        return (m_base != 0) && (m_mode || m_n < m_base);
    endfunction

    function automatic int m_count();
        if (!m_busy()) return 0;
        if (m_mode) return m_base - (m_n % m_base);
        return m_base - m_n;
    endfunction

    always @(posedge i_clk) begin
        exp_t e;
        if (!i_rst_n) begin
            m_base = 0; m_n = 0; m_mode = 0; m_pulse = 0; m_stick = 0; m_valid = 1;
        end else if (i_clear) begin
            m_base = 0; m_n = 0; m_pulse = 0; m_stick = 0;
        end else if (i_load) begin
            m_base = int'(i_load_val); m_mode = i_mode; m_n = 0; m_pulse = 0; m_stick = 0;
        end else if (m_busy() && i_en) begin
            m_n++;
            m_pulse = m_mode ? (m_n % m_base == 0) : (m_n == m_base);
            if (m_pulse) m_stick = 1;
        end else begin
            m_pulse = 0;
        end
        if (m_valid) begin
            e.sticky  = m_stick;
            e.expired = m_pulse;
            e.busy    = m_busy();
            e.count   = W'(m_count());
            exp_q.push_back(e);
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge i_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (o_count !== e.count) begin
                bad++;
                $display("FAIL sb_count t=%0t got=%0d want=%0d", $time, o_count, e.count);
            end
            total++;
            if (o_busy !== e.busy) begin
                bad++;
                $display("FAIL sb_busy t=%0t got=%b want=%b", $time, o_busy, e.busy);
            end
            total++;
            if (o_expired !== e.expired) begin
                bad++;
                $display("FAIL sb_expired t=%0t got=%b want=%b", $time, o_expired, e.expired);
            end
`ifdef COUNTDOWN_TIMER_STICKY_EN
            total++;
            if (o_expired_sticky !== e.sticky) begin
                bad++;
                $display("FAIL sb_sticky t=%0t got=%b want=%b", $time, o_expired_sticky, e.sticky);
            end
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst_n, input logic en, input logic clr, input logic ld,
                         input logic [W-1:0] val, input logic md);
        @(negedge i_clk);
        i_rst_n = rst_n; i_en = en; i_clear = clr; i_load = ld; i_load_val = val; i_mode = md;
        @(posedge i_clk);
        #1;
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) drive(1'b1, en, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        int first_p;
        int last_p;
        bit gap_ok;
        i_rst_n = 1'b0; i_en = 1'b0; i_clear = 1'b0; i_load = 1'b0; i_load_val = '0; i_mode = 1'b0;

        // 1. one-shot
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_expired", int'(o_expired), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, W'(10), 1'b0);
        chk("os_load", int'(o_count), 10);
        run(9, 1'b1);
        chk("os_at1", int'(o_count), 1);
        chk("os_at1_noexp", int'(o_expired), 0);
        run(1, 1'b1);
        chk("os_zero", int'(o_count), 0);
        chk("os_pulse", int'(o_expired), 1);
        chk("os_busy_fall", int'(o_busy), 0);
        run(1, 1'b1);
        chk("os_pulse_once", int'(o_expired), 0);

        // 2. hold
        drive(1'b1, 1'b0, 1'b0, 1'b1, W'(20), 1'b0);
        run(5, 1'b1);
        chk("hold_start", int'(o_count), 15);
        for (int i = 0; i < 10; i++) begin
            run(1, 1'b0);
            chk("hold_count", int'(o_count), 15);
            chk("hold_busy", int'(o_busy), 1);
            chk("hold_noexp", int'(o_expired), 0);
        end

        // 3. periodic
        drive(1'b1, 1'b0, 1'b0, 1'b1, W'(4), 1'b1);
        pulses = 0; first_p = -1; last_p = -1; gap_ok = 1;
        for (int k = 1; k <= 12; k++) begin
            run(1, 1'b1);
            chk("per_count", int'(o_count), 4 - (k % 4));
            chk("per_busy", int'(o_busy), 1);
            if (o_expired) begin
                if (last_p >= 0 && k - last_p != 4) gap_ok = 0;
                if (first_p < 0) first_p = k;
                last_p = k;
                pulses++;
            end
        end
        chk("per_pulses", pulses, 3);
        chk("per_first", first_p, 4);
        chk("per_gap", int'(gap_ok), 1);

        // 4. clear
        drive(1'b1, 1'b0, 1'b0, 1'b1, W'(50), 1'b0);
        run(5, 1'b1);
        chk("clr_pre", int'(o_count), 45);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        chk("clr_count", int'(o_count), 0);
        chk("clr_busy", int'(o_busy), 0);
        chk("clr_noexp", int'(o_expired), 0);
        run(10, 1'b1);
        chk("clr_stays0", int'(o_count), 0);

        // 5. collisions at the terminal edge
        drive(1'b1, 1'b0, 1'b0, 1'b1, W'(2), 1'b0);
        run(1, 1'b1);
        chk("col_at1", int'(o_count), 1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, W'(7), 1'b0);
        chk("col_load_count", int'(o_count), 7);
        chk("col_load_busy", int'(o_busy), 1);
        chk("col_load_noexp", int'(o_expired), 0);
        run(6, 1'b1);
        chk("col_at1b", int'(o_count), 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        chk("col_clr_count", int'(o_count), 0);
        chk("col_clr_noexp", int'(o_expired), 0);

        // 6. reset mid-run
        drive(1'b1, 1'b0, 1'b0, 1'b1, W'(100), 1'b0);
        run(3, 1'b1);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("mr_hold_count", int'(o_count), 97);
        chk("mr_hold_busy", int'(o_busy), 1);
        @(posedge i_clk);
        #1;
        chk("mr_count", int'(o_count), 0);
        chk("mr_busy", int'(o_busy), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, W'(0), 1'b1);
        chk("ld0_busy", int'(o_busy), 0);
        chk("ld0_noexp", int'(o_expired), 0);
        run(2, 1'b1);
        chk("ld0_stays", int'(o_expired), 0);

        // random traffic, checked by the scoreboard each cycle
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] v;
            v = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 5));
            drive(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 9) == 0),
                  v,
                  1'($urandom_range(0, 1)));
        end
        run(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
